// File: rtl/seg7_scan_mux_if.sv
// Value/display bundle between the datapath (master) and the 7-segment scan driver (slave).
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS  = 8,
  parameter int BRIGHT_BITS = 3
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dots;
  logic                    blank_lz;
  logic [BRIGHT_BITS-1:0]  brightness;
  logic [7:0]              segment;
  logic [NUM_DIGITS-1:0]   digit;
  logic                    frame_start;

  modport master (
    output value, dots, blank_lz, brightness,
    input  segment, digit, frame_start
  );

  modport slave (
    input  value, dots, blank_lz, brightness,
    output segment, digit, frame_start
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Multiplexed hex display driver: scans NUM_DIGITS digits with PWM dimming,
// leading-zero blanking and a once-per-frame input snapshot so a frame never tears.
module seg7_scan_mux #(
  parameter int NUM_DIGITS  = 8,
  parameter int PRESCALE    = 1024,
  parameter int BRIGHT_BITS = 3,
  parameter int ACTIVE_LOW  = 1
) (
  input logic            clock,
  input logic            reset,
  seg7_scan_mux_if.slave bus
);
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [BRIGHT_BITS-1:0] PH_MAX  = {BRIGHT_BITS{1'b1}};
  localparam logic [IDX_W-1:0]       IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic                   POL     = (ACTIVE_LOW != 0);

  function automatic logic [6:0] font(input logic [3:0] nib);
    logic [6:0] f;
    case (nib)
      4'h0:    f = 7'h3F;
      4'h1:    f = 7'h06;
      4'h2:    f = 7'h5B;
      4'h3:    f = 7'h4F;
      4'h4:    f = 7'h66;
      4'h5:    f = 7'h6D;
      4'h6:    f = 7'h7D;
      4'h7:    f = 7'h07;
      4'h8:    f = 7'h7F;
      4'h9:    f = 7'h6F;
      4'hA:    f = 7'h77;
      4'hB:    f = 7'h7C;
      4'hC:    f = 7'h39;
      4'hD:    f = 7'h5E;
      4'hE:    f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dots_q;
  logic                    blank_lz_q;
  logic [BRIGHT_BITS-1:0]  bright_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BRIGHT_BITS-1:0]  ph_q, ph_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fs_q, fs_d;

  logic                    cnt_wrap_s, ph_wrap_s, frame_end_s, en_s, zero_run_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic [3:0]              nib_s;
  logic [7:0]              seg_hi_s;
  logic [NUM_DIGITS-1:0]   dig_hi_s;

  // Scan counters, blanking mask and next output image from the pre-edge state
  always_comb begin
    cnt_wrap_s  = (cnt_q == CNT_MAX);
    ph_wrap_s   = (ph_q == PH_MAX);
    frame_end_s = cnt_wrap_s && ph_wrap_s && (idx_q == IDX_MAX);

    cnt_d = cnt_wrap_s ? '0 : cnt_q + CNT_W'(1);
    ph_d  = ph_q;
    idx_d = idx_q;
    if (cnt_wrap_s) begin
      ph_d = ph_q + BRIGHT_BITS'(1);
      if (ph_wrap_s) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end else begin
        idx_d = idx_q;
      end
    end else begin
      ph_d = ph_q;
    end

    // A digit is blank only if it and every more significant nibble are zero
    zero_run_s = 1'b1;
    blank_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (value_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        blank_s[i] = zero_run_s && blank_lz_q;
      end else begin
        blank_s[i] = 1'b0;
      end
    end

    nib_s    = value_q[{idx_q, 2'b00} +: 4];
    en_s     = (ph_q <= bright_q);
    seg_hi_s = 8'h00;
    dig_hi_s = '0;
    if (en_s) begin
      seg_hi_s        = {dots_q[idx_q], blank_s[idx_q] ? 7'h00 : font(nib_s)};
      dig_hi_s[idx_q] = 1'b1;
    end else begin
      seg_hi_s = 8'h00;
    end

    seg_d = seg_hi_s ^ {8{POL}};
    dig_d = dig_hi_s ^ {NUM_DIGITS{POL}};
    fs_d  = (cnt_q == '0) && (ph_q == '0) && (idx_q == '0);
  end

  // State, snapshot and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      ph_q       <= '0;
      idx_q      <= '0;
      seg_q      <= {8{POL}};
      dig_q      <= {NUM_DIGITS{POL}};
      fs_q       <= 1'b0;
      value_q    <= bus.value;
      dots_q     <= bus.dots;
      blank_lz_q <= bus.blank_lz;
      bright_q   <= bus.brightness;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      fs_q  <= fs_d;
      if (frame_end_s) begin
        value_q    <= bus.value;
        dots_q     <= bus.dots;
        blank_lz_q <= bus.blank_lz;
        bright_q   <= bus.brightness;
      end else begin
        value_q    <= value_q;
        dots_q     <= dots_q;
        blank_lz_q <= blank_lz_q;
        bright_q   <= bright_q;
      end
    end
  end

  assign bus.segment     = seg_q;
  assign bus.digit       = dig_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus randomized traffic
// checked against a cycle-count based reference model.
module tb_seg7_scan_mux;
  localparam int ND    = 4;
  localparam int PS    = 1;
  localparam int BB    = 2;
  localparam int AL    = 1;
  localparam int SLOT  = PS * (1 << BB);
  localparam int FRAME = ND * SLOT;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seg7_scan_mux_if #(.NUM_DIGITS(ND), .BRIGHT_BITS(BB)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS(ND), .PRESCALE(PS), .BRIGHT_BITS(BB), .ACTIVE_LOW(AL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: cycles since reset release plus the frame's snapshot
  int          m_s;
  logic [15:0] sv;
  logic [3:0]  sd;
  logic        sb;
  logic [1:0]  sbr;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_fs;

  task automatic predict();
    int pos, d, ph;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic        blanked;
    pos    = m_s % FRAME;
    d      = pos / SLOT;
    ph     = (pos % SLOT) / PS;
    exp_fs = (pos == 0);
    upper  = sv >> (4 * d);
    nib    = upper[3:0];
    if (ph > int'(sbr)) begin
      exp_seg = 8'hFF;
      exp_dig = 4'hF;
    end else begin
      blanked = sb && (d != 0) && (upper == 16'h0000);
      exp_seg = ~{sd[d], blanked ? 7'h00 : font_tab[nib]};
      exp_dig = ~(4'b0001 << d);
    end
  endtask

  task automatic cycle();
    logic [15:0] cv;
    logic [3:0]  cd;
    logic        cb, cr;
    logic [1:0]  cbr;
    cv = bus.value; cd = bus.dots; cb = bus.blank_lz; cbr = bus.brightness; cr = reset;
    @(posedge clock);
    if (cr) begin
      exp_seg = 8'hFF; exp_dig = 4'hF; exp_fs = 1'b0;
      m_s = 0; sv = cv; sd = cd; sb = cb; sbr = cbr;
    end else begin
      predict();
      if (m_s % FRAME == FRAME - 1) begin
        sv = cv; sd = cd; sb = cb; sbr = cbr;
      end
      m_s++;
    end
    #1;
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] d, input logic b,
                            input logic [1:0] br);
    bus.value = v; bus.dots = d; bus.blank_lz = b; bus.brightness = br;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_inputs(16'h1234, 4'h0, 1'b0, 2'd3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.segment !== 8'hFF || bus.digit !== 4'hF || bus.frame_start !== 1'b0)
        $display("FAIL reset_state cyc=%0d seg=%h dig=%h fs=%b want FF/F/0",
                 i, bus.segment, bus.digit, bus.frame_start);
      else passes++;
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (bus.frame_start !== 1'b1 || bus.digit !== 4'hE || bus.segment !== 8'h99)
      $display("FAIL first_after_reset seg=%h dig=%h fs=%b want 99/E/1",
               bus.segment, bus.digit, bus.frame_start);
    else passes++;
  endtask

  task automatic test_scan();
    logic [7:0] tab [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    int pos;
    for (int k = 1; k < 2 * FRAME; k++) begin
      cycle();
      pos = k % FRAME;
      checks++;
      if (bus.segment !== tab[pos / SLOT] || bus.digit !== ~(4'b0001 << (pos / SLOT)) ||
          bus.frame_start !== (pos == 0))
        $display("FAIL scan_1234 k=%0d seg=%h dig=%h fs=%b want %h/%h/%b", k, bus.segment,
                 bus.digit, bus.frame_start, tab[pos / SLOT], ~(4'b0001 << (pos / SLOT)), pos == 0);
      else passes++;
    end
  endtask

  task automatic test_pwm();
    int on_cnt [4];
    set_inputs(16'h0008, 4'h0, 1'b0, 2'd1);
    pulse_reset();
    for (int d = 0; d < ND; d++) on_cnt[d] = 0;
    for (int k = 0; k < FRAME; k++) begin
      cycle();
      if (bus.digit !== 4'hF) on_cnt[k / SLOT]++;
      checks++;
      if (bus.segment !== exp_seg || bus.digit !== exp_dig || bus.frame_start !== exp_fs)
        $display("FAIL pwm_model k=%0d seg=%h dig=%h fs=%b want %h/%h/%b", k,
                 bus.segment, bus.digit, bus.frame_start, exp_seg, exp_dig, exp_fs);
      else passes++;
      if (bus.digit === 4'hE) begin
        checks++;
        if (bus.segment !== 8'h80) $display("FAIL pwm_digit0_seg seg=%h want 80", bus.segment);
        else passes++;
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (on_cnt[d] != 2) $display("FAIL pwm_duty digit=%0d on=%0d want 2", d, on_cnt[d]);
      else passes++;
    end
  endtask

  task automatic test_blank();
    logic [7:0] tab_a [4] = '{8'hA4, 8'hF9, 8'hFF, 8'h7F};
    logic [7:0] tab_b [4] = '{8'hC0, 8'hFF, 8'hFF, 8'h7F};
    for (int pass = 0; pass < 2; pass++) begin
      set_inputs(pass == 0 ? 16'h0012 : 16'h0000, 4'b1000, 1'b1, 2'd3);
      pulse_reset();
      for (int k = 0; k < FRAME; k++) begin
        cycle();
        checks++;
        if (bus.segment !== (pass == 0 ? tab_a[k / SLOT] : tab_b[k / SLOT]) ||
            bus.segment !== exp_seg || bus.digit !== exp_dig)
          $display("FAIL blank_lz pass=%0d k=%0d seg=%h dig=%h want %h/%h", pass, k,
                   bus.segment, bus.digit, exp_seg, exp_dig);
        else passes++;
      end
    end
  endtask

  task automatic test_snapshot();
    logic [7:0] want;
    set_inputs(16'h1111, 4'h0, 1'b0, 2'd3);
    pulse_reset();
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle();
      want = (k < FRAME) ? 8'hF9 : 8'hA4;
      checks++;
      if (bus.segment !== want || bus.segment !== exp_seg || bus.frame_start !== exp_fs)
        $display("FAIL snapshot k=%0d seg=%h fs=%b want %h/%b", k, bus.segment,
                 bus.frame_start, want, exp_fs);
      else passes++;
      if (k == 5) bus.value = 16'h2222;
    end
  endtask

  task automatic test_reset_mid();
    set_inputs(16'hBEEF, 4'b0101, 1'b0, 2'd3);
    pulse_reset();
    repeat (10) cycle();
    reset = 1'b1;
    cycle();
    checks++;
    if (bus.segment !== 8'hFF || bus.digit !== 4'hF || bus.frame_start !== 1'b0)
      $display("FAIL reset_mid_off seg=%h dig=%h fs=%b want FF/F/0",
               bus.segment, bus.digit, bus.frame_start);
    else passes++;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      checks++;
      if (bus.segment !== exp_seg || bus.digit !== exp_dig || bus.frame_start !== exp_fs ||
          (k == 0 && (bus.frame_start !== 1'b1 || bus.digit !== 4'hE)))
        $display("FAIL reset_mid_restart k=%0d seg=%h dig=%h fs=%b want %h/%h/%b", k,
                 bus.segment, bus.digit, bus.frame_start, exp_seg, exp_dig, exp_fs);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      set_inputs(16'($urandom), 4'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
      if (($urandom & 1) == 1) pulse_reset();
      for (int k = 0; k < 40; k++) begin
        cycle();
        checks++;
        if (bus.segment !== exp_seg || bus.digit !== exp_dig || bus.frame_start !== exp_fs ||
            $countones(~bus.digit) > 1)
          $display("FAIL random r=%0d k=%0d seg=%h dig=%h fs=%b want %h/%h/%b", r, k,
                   bus.segment, bus.digit, bus.frame_start, exp_seg, exp_dig, exp_fs);
        else passes++;
        if ($urandom_range(0, 7) == 0) begin
          bus.value = 16'($urandom);
          if ($urandom_range(0, 2) == 0) bus.value[15:8] = 8'h00;
          bus.dots       = 4'($urandom);
          bus.blank_lz   = 1'($urandom);
          bus.brightness = 2'($urandom_range(0, 3));
        end
      end
    end
  endtask

  initial begin
    m_s = 0; sv = '0; sd = '0; sb = 1'b0; sbr = '0;
    exp_seg = 8'hFF; exp_dig = 4'hF; exp_fs = 1'b0;
    test_reset();
    test_scan();
    test_pwm();
    test_blank();
    test_snapshot();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
